// File: rtl/fetch_line_queue_if.sv
// Handshake bundle between the fetch unit, the line queue and the decode stage.
// The master drives enqueue, flush and deq_ready; the slave is the queue itself.
interface fetch_line_queue_if #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                flush;
    logic                enq_even_valid;
    logic                enq_odd_valid;
    logic [XLEN-1:0]     enq_even_addr;
    logic [XLEN-1:0]     enq_odd_addr;
    logic [CL_SIZE-1:0]  enq_even_line;
    logic [CL_SIZE-1:0]  enq_odd_line;
    logic                enq_even_exc;
    logic                enq_odd_exc;
    logic                enq_first_odd;
    logic                enq_ready;
    logic                deq_valid;
    logic                deq_ready;
    logic [31:0]         deq_instr;
    logic [XLEN-1:0]     deq_pc;
    logic                deq_exc;
    logic [CW-1:0]       count;

    modport master (
        output flush, enq_even_valid, enq_odd_valid, enq_even_addr, enq_odd_addr,
               enq_even_line, enq_odd_line, enq_even_exc, enq_odd_exc, enq_first_odd,
               deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc, deq_exc, count
    );

    modport slave (
        input  flush, enq_even_valid, enq_odd_valid, enq_even_addr, enq_odd_addr,
               enq_even_line, enq_odd_line, enq_even_exc, enq_odd_exc, enq_first_odd,
               deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc, deq_exc, count
    );
endinterface

// File: rtl/fetch_line_queue.sv
// Queue of fetched cache lines, accepting up to two lines per cycle and
// handing out one 32-bit instruction word per cycle with its PC.
module fetch_line_queue #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    fetch_line_queue_if.slave  bus
);
    localparam int OFF  = $clog2(CL_SIZE / 8);
    localparam int WPL  = CL_SIZE / 32;
    localparam int WIDX = $clog2(WPL);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [WIDX-1:0] WP_ONE    = WIDX'(1);
    localparam logic [WIDX-1:0] WP_LAST   = WIDX'(WPL - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   READY_MAX = CW'(DEPTH - 2);

    logic [XLEN-1:0]    addr_mem [DEPTH];
    logic [CL_SIZE-1:0] line_mem [DEPTH];
    logic               exc_mem  [DEPTH];
    logic [WIDX-1:0]    sw_mem   [DEPTH];

    logic [PW-1:0]   head_r, tail_r;
    logic [WIDX-1:0] wp_r;
    logic [CW-1:0]   count_r;

    logic [PW-1:0]      head_nxt_s, tail_nxt_s;
    logic [WIDX-1:0]    wp_nxt_s;
    logic [CW-1:0]      count_nxt_s;
    logic               ready_s, valid_s, acc_s, dual_s, xfer_s, pop_s;
    logic [1:0]         n_enq_s;
    logic [XLEN-1:0]    old_addr_s, yng_addr_s, head_addr_s;
    logic [CL_SIZE-1:0] old_line_s, yng_line_s, head_line_s;
    logic               old_exc_s, yng_exc_s;
    logic [WIDX-1:0]    old_sw_s, yng_sw_s;

    // Enqueue acceptance and older/younger channel ordering.
    always_comb begin
        ready_s = (count_r <= READY_MAX);
        valid_s = (count_r != {CW{1'b0}});
        dual_s  = bus.enq_even_valid && bus.enq_odd_valid;
        acc_s   = ready_s && !bus.flush && (bus.enq_even_valid || bus.enq_odd_valid);
        if (!acc_s) begin
            n_enq_s = 2'd0;
        end else if (dual_s) begin
            n_enq_s = 2'd2;
        end else begin
            n_enq_s = 2'd1;
        end
        if ((dual_s && bus.enq_first_odd) || (!dual_s && !bus.enq_even_valid)) begin
            old_addr_s = bus.enq_odd_addr;  old_line_s = bus.enq_odd_line;  old_exc_s = bus.enq_odd_exc;
            yng_addr_s = bus.enq_even_addr; yng_line_s = bus.enq_even_line; yng_exc_s = bus.enq_even_exc;
        end else begin
            old_addr_s = bus.enq_even_addr; old_line_s = bus.enq_even_line; old_exc_s = bus.enq_even_exc;
            yng_addr_s = bus.enq_odd_addr;  yng_line_s = bus.enq_odd_line;  yng_exc_s = bus.enq_odd_exc;
        end
        old_sw_s = old_addr_s[OFF-1:2];
        yng_sw_s = yng_addr_s[OFF-1:2];
    end

    // Dequeue handshake and head-entry output formatting.
    always_comb begin
        head_addr_s = addr_mem[head_r];
        head_line_s = line_mem[head_r];
        xfer_s      = valid_s && bus.deq_ready && !bus.flush;
        pop_s       = xfer_s && (exc_mem[head_r] || (wp_r == WP_LAST));
        if (valid_s && exc_mem[head_r]) begin
            bus.deq_exc   = 1'b1;
            bus.deq_instr = 32'h0000_0013;
            bus.deq_pc    = {head_addr_s[XLEN-1:2], 2'b00};
        end else begin
            bus.deq_exc   = 1'b0;
            bus.deq_instr = head_line_s[{wp_r, 5'd0} +: 32];
            bus.deq_pc    = {head_addr_s[XLEN-1:OFF], wp_r, 2'b00};
        end
        bus.deq_valid = valid_s;
        bus.enq_ready = ready_s;
        bus.count     = count_r;
    end

    // Next pointer/count/word-pointer state; flush overrides everything.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        wp_nxt_s    = wp_r;
        if (bus.flush) begin
            head_nxt_s  = {PW{1'b0}};
            tail_nxt_s  = {PW{1'b0}};
            count_nxt_s = {CW{1'b0}};
            wp_nxt_s    = {WIDX{1'b0}};
        end else begin
            tail_nxt_s  = tail_r + PW'(n_enq_s);
            count_nxt_s = count_r + CW'(n_enq_s) - CW'(pop_s);
            if (pop_s) begin
                head_nxt_s = head_r + PTR_ONE;
                // Last entry leaving while a new line arrives: the new line is not in memory yet.
                if (count_r == CNT_ONE) begin
                    if (acc_s) begin
                        wp_nxt_s = old_sw_s;
                    end else begin
                        wp_nxt_s = {WIDX{1'b0}};
                    end
                end else begin
                    wp_nxt_s = sw_mem[head_r + PTR_ONE];
                end
            end else if (xfer_s) begin
                wp_nxt_s = wp_r + WP_ONE;
            end else if (!valid_s && acc_s) begin
                wp_nxt_s = old_sw_s;
            end else begin
                wp_nxt_s = wp_r;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            wp_r    <= {WIDX{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            wp_r    <= wp_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are meaningless until the entry is counted.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            addr_mem[tail_r] <= old_addr_s;
            line_mem[tail_r] <= old_line_s;
            exc_mem[tail_r]  <= old_exc_s;
            sw_mem[tail_r]   <= old_sw_s;
            if (dual_s) begin
                addr_mem[tail_r + PTR_ONE] <= yng_addr_s;
                line_mem[tail_r + PTR_ONE] <= yng_line_s;
                exc_mem[tail_r + PTR_ONE]  <= yng_exc_s;
                sw_mem[tail_r + PTR_ONE]   <= yng_sw_s;
            end
        end
    end
endmodule

// File: tb/tb_fetch_line_queue.sv
// Directed bench: stimulus pushes hand-computed beats into a scoreboard queue,
// a negedge monitor pops and compares every word the queue hands out.
module tb_fetch_line_queue;
    typedef struct packed {
        logic        exc;
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    total = 0;
    int    passed = 0;
    beat_t exp_q[$];

    fetch_line_queue_if #(.XLEN(32), .CL_SIZE(128), .DEPTH(4)) bus ();

    fetch_line_queue #(.XLEN(32), .CL_SIZE(128), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Monitor: every beat that will transfer at the next rising edge is scored.
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.deq_valid && bus.deq_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: got pc %0h instr %0h, no beat expected", bus.deq_pc, bus.deq_instr);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat", {bus.deq_exc, bus.deq_pc, bus.deq_instr}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic exc);
        beat_t b;
        b.exc = exc; b.pc = pc; b.instr = instr;
        exp_q.push_back(b);
    endtask

    task automatic enq(input bit odd, input logic [31:0] addr, input logic [127:0] line, input logic exc);
        if (odd) begin
            bus.enq_odd_valid = 1'b1; bus.enq_odd_addr = addr; bus.enq_odd_line = line; bus.enq_odd_exc = exc;
        end else begin
            bus.enq_even_valid = 1'b1; bus.enq_even_addr = addr; bus.enq_even_line = line; bus.enq_even_exc = exc;
        end
        tick();
        bus.enq_even_valid = 1'b0;
        bus.enq_odd_valid  = 1'b0;
    endtask

    task automatic drain(input string name, input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (exp_q.size() == 0 && !bus.deq_valid) begin
                done = 1'b1;
            end else begin
                if (toggle) bus.deq_ready = ~bus.deq_ready;
                tick();
            end
        end
        bus.deq_ready = 1'b1;
        check({name, "_drained"}, {127'd0, done}, 128'd1);
        check({name, "_left"}, 128'(exp_q.size()), 128'd0);
        check({name, "_count"}, 128'(bus.count), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.flush = 1'b0; bus.enq_first_odd = 1'b0; bus.deq_ready = 1'b1;
        bus.enq_even_valid = 1'b0; bus.enq_odd_valid = 1'b0;
        bus.enq_even_addr = 32'h0; bus.enq_odd_addr = 32'h0;
        bus.enq_even_line = 128'h0; bus.enq_odd_line = 128'h0;
        bus.enq_even_exc = 1'b0; bus.enq_odd_exc = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_count", 128'(bus.count), 128'd0);
        check("rst_deq_valid", {127'd0, bus.deq_valid}, 128'd0);
        check("rst_enq_ready", {127'd0, bus.enq_ready}, 128'd1);
        check("rst_deq_exc", {127'd0, bus.deq_exc}, 128'd0);

        // Full line from word 0.
        push(32'h11111111, 32'h1000, 1'b0); push(32'h22222222, 32'h1004, 1'b0);
        push(32'h33333333, 32'h1008, 1'b0); push(32'h44444444, 32'h100C, 1'b0);
        enq(1'b0, 32'h1000, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0);
        check("latency_valid", {127'd0, bus.deq_valid}, 128'd1);
        drain("line0", 1'b0);

        // Line entered mid-way.
        push(32'hA2A2A2A2, 32'h2008, 1'b0); push(32'hA3A3A3A3, 32'h200C, 1'b0);
        enq(1'b1, 32'h2008, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 1'b0);
        drain("mid", 1'b0);

        // Dual enqueue, odd line older, consumer stalls every other cycle.
        for (int k = 0; k < 4; k++) push(32'hB0B0B0B0 + 32'h01010101 * k, 32'h3000 + 32'd4 * k, 1'b0);
        for (int k = 0; k < 4; k++) push(32'hC0C0C0C0 + 32'h01010101 * k, 32'h3010 + 32'd4 * k, 1'b0);
        bus.enq_first_odd = 1'b1;
        bus.enq_even_valid = 1'b1; bus.enq_even_addr = 32'h3010; bus.enq_even_exc = 1'b0;
        bus.enq_even_line = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        enq(1'b1, 32'h3000, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}, 1'b0);
        bus.enq_first_odd = 1'b0;
        check("dual_count", 128'(bus.count), 128'd2);
        drain("dual", 1'b1);

        // Fill to three entries, fourth enqueue refused.
        bus.deq_ready = 1'b0;
        push(32'h50505050, 32'h500C, 1'b0); push(32'h51515151, 32'h510C, 1'b0); push(32'h52525252, 32'h520C, 1'b0);
        enq(1'b0, 32'h500C, {32'h50505050, 96'h0}, 1'b0);
        enq(1'b1, 32'h510C, {32'h51515151, 96'h0}, 1'b0);
        check("fill2_ready", {127'd0, bus.enq_ready}, 128'd1);
        enq(1'b0, 32'h520C, {32'h52525252, 96'h0}, 1'b0);
        check("fill3_count", 128'(bus.count), 128'd3);
        check("fill3_ready", {127'd0, bus.enq_ready}, 128'd0);
        enq(1'b1, 32'h530C, {32'h53535353, 96'h0}, 1'b0);
        check("drop_count", 128'(bus.count), 128'd3);
        bus.deq_ready = 1'b1;
        drain("fill", 1'b0);

        // Last beat of the only entry pops while a new line arrives.
        push(32'h92929292, 32'h9008, 1'b0); push(32'h93939393, 32'h900C, 1'b0);
        push(32'h96969696, 32'h9104, 1'b0); push(32'h97979797, 32'h9108, 1'b0); push(32'h98989898, 32'h910C, 1'b0);
        enq(1'b0, 32'h9008, {32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090}, 1'b0);
        tick();
        enq(1'b1, 32'h9104, {32'h98989898, 32'h97979797, 32'h96969696, 32'h95959595}, 1'b0);
        check("enq_pop_count", 128'(bus.count), 128'd1);
        drain("enq_pop", 1'b0);

        // Flush on the second beat with a simultaneous enqueue.
        push(32'hD0D0D0D0, 32'h6000, 1'b0);
        enq(1'b0, 32'h6000, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0}, 1'b0);
        tick();
        bus.flush = 1'b1;
        enq(1'b1, 32'h7000, {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0}, 1'b0);
        bus.flush = 1'b0;
        check("flush_count", 128'(bus.count), 128'd0);
        check("flush_valid", {127'd0, bus.deq_valid}, 128'd0);
        tick(); tick();
        check("flush_dropped", {127'd0, bus.deq_valid}, 128'd0);
        drain("flush", 1'b0);

        // Exception line: a single nop beat at the word-aligned fetch address.
        push(32'h00000013, 32'h4004, 1'b1);
        enq(1'b0, 32'h4006, {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0}, 1'b1);
        drain("exc", 1'b0);

        // Reset in mid-stream discards queued lines.
        bus.deq_ready = 1'b0;
        enq(1'b1, 32'h8004, {32'h83838383, 32'h82828282, 32'h81818181, 32'h80808080}, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", 128'(bus.count), 128'd0);
        check("mid_rst_valid", {127'd0, bus.deq_valid}, 128'd0);
        check("mid_rst_ready", {127'd0, bus.enq_ready}, 128'd1);
        tick();
        rst = 1'b0;
        bus.deq_ready = 1'b1;
        push(32'h8A8A8A8A, 32'h8008, 1'b0); push(32'h8B8B8B8B, 32'h800C, 1'b0);
        enq(1'b0, 32'h8008, {32'h8B8B8B8B, 32'h8A8A8A8A, 32'h89898989, 32'h88888888}, 1'b0);
        drain("post_rst", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_line_queue.md
FETCH_LINE_QUEUE -- requirements
Module: fetch_line_queue

Interface
REQ-001 Parameter XLEN, default 32, address and PC width.
REQ-002 Parameter CL_SIZE, default 128, cache-line width in bits; power of 2, at least 64; WPL = CL_SIZE/32 words per line.
REQ-003 Parameter DEPTH, default 4, line entries; power of 2, at least 2.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  resteer; discards all queued state.
REQ-007 enq_even_valid / enq_odd_valid  in  1 each  line present on the even / odd channel.
REQ-008 enq_even_addr / enq_odd_addr  in  XLEN each  fetch address of the line; bits [log2(CL_SIZE/8)-1:2] give the start word.
REQ-009 enq_even_line / enq_odd_line  in  CL_SIZE each  line data; word k = bits [32k+31:32k].
REQ-010 enq_even_exc / enq_odd_exc  in  1 each  fetch exception for the line.
REQ-011 enq_first_odd  in  1  on a dual enqueue, odd line is older.
REQ-012 enq_ready  out  1  at least 2 free entries.
REQ-013 deq_valid  out  1  instruction word available.
REQ-014 deq_ready  in  1  consumer accepts the word.
REQ-015 deq_instr  out  32  instruction word.
REQ-016 deq_pc  out  XLEN  PC of deq_instr.
REQ-017 deq_exc  out  1  word carries a fetch exception.
REQ-018 count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-019 Circular buffer; head/tail pointers wrap modulo DEPTH; each entry holds addr, line, exc and a start word index.
REQ-020 enq_ready = (DEPTH - count >= 2), computed from the registered count only, never from same-cycle dequeue.
REQ-021 An enqueue is accepted only when enq_ready = 1 and flush = 0; valid channels presented otherwise are dropped with no state change.
REQ-022 Dual enqueue writes the older line at tail and the younger at tail+1; count += 2.
REQ-023 Single enqueue, on either channel, writes at tail; count += 1.
REQ-024 deq_valid = (count != 0); deq_instr, deq_pc and deq_exc are driven combinationally from the head entry and the registered word pointer wp.
REQ-025 deq_pc = {head addr[XLEN-1:log2(CL_SIZE/8)], wp, 2'b00}; deq_instr = head line word wp.
REQ-026 When a line becomes head, wp is loaded with that line's start word index; the first line ever enqueued and the first line after a flush start at their own address word.
REQ-027 Handshake: a beat transfers when deq_valid and deq_ready are both 1; while deq_ready = 0, all deq outputs hold stable.
REQ-028 On a transfer with wp < WPL-1 and head exc = 0: wp increments.
REQ-029 On a transfer with wp = WPL-1 or head exc = 1: the head pops, count -= 1, and wp loads the next entry's start word.
REQ-030 Exception entry: exactly one beat with deq_exc = 1, deq_instr = 32'h00000013 and deq_pc = entry addr with bits [1:0] forced to 0.
REQ-031 Same-cycle enqueue and pop: count = count + enqueued - 1.
REQ-032 Flush has priority: head, tail, wp and count are set to 0; deq_valid is 0 in the following cycle; a same-cycle transfer is discarded.
REQ-033 Latency: a line enqueued at edge N into an empty queue gives deq_valid = 1 after edge N.

Reset
REQ-034 rst asynchronously clears head, tail, wp and count; deq_valid = 0, enq_ready = 1, deq_exc = 0.
REQ-035 Entry data is not reset; outputs are don't-care while deq_valid = 0.
REQ-036 rst asserted mid-stream discards all entries; the first cycle after deassert behaves as post-reset.

Verification
REQ-037 Even enq addr 0x1000, words 0x11111111..0x44444444, deq_ready = 1 -> 4 beats, pc 0x1000/0x1004/0x1008/0x100C, instr in order; then count 0, deq_valid 0.
REQ-038 Enq addr 0x2008 -> 2 beats, pc 0x2008 then 0x200C; then pop.
REQ-039 Dual enq, even 0x3010, odd 0x3000, enq_first_odd = 1 -> 8 beats, pc 0x3000..0x301C ascending; deq_ready toggled 1/0 -> no beat lost or repeated.
REQ-040 DEPTH 4: three single enqueues with no dequeue -> count 3, enq_ready 0; a 4th enqueue with enq_ready = 0 is dropped, count stays 3.
REQ-041 Flush on the 2nd beat of a line plus a simultaneous valid enqueue -> count 0, deq_valid 0 the next cycle, enqueue dropped.
REQ-042 Enq addr 0x4006 with exc = 1 -> one beat, pc 0x4004, instr 0x00000013, deq_exc 1; then pop.
